// File: rtl/mat_unskew_collector.sv
`default_nettype none
// ============================================================================
//  Module      : mat_unskew_collector
//  Description : Re-aligns the diagonally skewed result vectors emitted by the
//                MatUnit systolic array into full-width words and buffers them
//                in a small circular FIFO behind a valid/ready handshake.
//                Exports a conservative credit (in_ready) and a sticky
//                overflow flag, since the array itself cannot stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module mat_unskew_collector #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           in_valid,
    input  logic [N-1:0][WIDTH-1:0]        in_data,
    output logic                           in_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N-1:0][WIDTH-1:0]        out_data,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           overflow
);

    // Width of the occupancy counter (must represent 0..DEPTH).
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    // Pointer width; a single-entry FIFO still needs a one-bit pointer.
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Width wide enough for occupancy plus in-flight vectors.
    localparam int c_sum_w = $clog2(DEPTH + N + 1);

    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr  = c_ptr_w'(DEPTH - 1);
    localparam logic [c_sum_w-1:0] c_depth_sum = c_sum_w'(DEPTH);

    // ------------------------------------------------------------------
    // Deskew datapath and valid shift line
    // ------------------------------------------------------------------
    logic [N-1:0][WIDTH-1:0] w_aligned;
    logic                    w_dvalid;
    logic [c_sum_w-1:0]      w_inflight;

    // Lane i arrives i cycles after lane 0, so it is delayed by N-1-i
    // registers; the last lane goes straight through.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        localparam int c_stages = N - 1 - gi;
        if (c_stages == 0) begin : g_pass
            assign w_aligned[gi] = in_data[gi];
        end else begin : g_dly
            logic [WIDTH-1:0] r_pipe [c_stages];

            // Data-only delay line; contents are don't-care until a valid
            // token reaches the end of the valid shift line.
            always_ff @(posedge clock) begin
                r_pipe[0] <= in_data[gi];
                for (int k = 1; k < c_stages; k++) begin
                    r_pipe[k] <= r_pipe[k-1];
                end
            end

            assign w_aligned[gi] = r_pipe[c_stages-1];
        end
    end

    // The valid token travels alongside lane 0 so it emerges in the same
    // cycle the last lane of the vector arrives.
    if (N == 1) begin : g_no_skew
        assign w_dvalid   = in_valid;
        assign w_inflight = '0;
    end else begin : g_skew
        logic [N-2:0] r_vld;

        // Valid shift line; cleared on reset so pre-reset vectors vanish.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_vld <= '0;
            end else begin
                r_vld[0] <= in_valid;
                for (int k = 1; k <= N - 2; k++) begin
                    r_vld[k] <= r_vld[k-1];
                end
            end
        end

        // Count vectors already launched but not yet at the FIFO.
        always_comb begin
            w_inflight = '0;
            for (int k = 0; k < N - 1; k++) begin
                w_inflight = w_inflight + c_sum_w'(r_vld[k]);
            end
        end

        assign w_dvalid = r_vld[N-2];
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [N-1:0][WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [c_cnt_w-1:0]      r_count;
    logic                    r_overflow;

    logic w_full;
    logic w_pop;
    logic w_push;

    function automatic logic [c_ptr_w-1:0] f_next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign w_full    = (r_count == c_depth);
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO can still
    // take the incoming vector.
    assign w_push    = w_dvalid && (!w_full || w_pop);

    // Credit comes from registers only: a same-cycle pop is deliberately not
    // credited, keeping in_ready free of any combinational path from out_ready.
    assign in_ready  = ((c_sum_w'(r_count) + w_inflight) < c_depth_sum);

    assign out_data  = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign overflow  = r_overflow;

    // Storage write; no reset needed since empty slots are never presented.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_aligned;
        end
    end

    // Pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if (w_dvalid && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mat_unskew_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mat_unskew_collector
//  Description : Self-checking bench for mat_unskew_collector (N=4, DEPTH=2).
//                Drives skewed vectors, scoreboards popped output words and
//                checks handshake, credit, overflow and reset behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mat_unskew_collector;

    localparam int N     = 4;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef logic [N-1:0][WIDTH-1:0] vec_t;

    logic           clock   = 1'b0;
    logic           reset_n = 1'b1;
    logic           in_valid;
    vec_t           in_data;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    vec_t           out_data;
    logic [CW-1:0]  count;
    logic           overflow;

    int n_checks = 0;
    int n_pass   = 0;

    vec_t sb_q [$];
    vec_t sb_exp;
    vec_t hist   [N];
    bit   hist_v [N];

    mat_unskew_collector #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [N*WIDTH-1:0] obs,
                         input logic [N*WIDTH-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic vec_t mkv(input logic [31:0] x);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = x;
        return v;
    endfunction

    // Lane-distinct vector so lane swaps are visible.
    function automatic vec_t mkl(input logic [31:0] base);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = base + 32'(i);
        return v;
    endfunction

    // Apply one cycle of skewed input: lane i carries lane i of the vector
    // launched i cycles ago, filler elsewhere.
    task automatic drive(input bit launch, input vec_t v, input bit ordy);
        for (int i = N - 1; i > 0; i--) begin
            hist[i]   = hist[i-1];
            hist_v[i] = hist_v[i-1];
        end
        hist[0]   = v;
        hist_v[0] = launch;
        in_valid  = launch;
        out_ready = ordy;
        for (int i = 0; i < N; i++)
            in_data[i] = hist_v[i] ? hist[i][i] : 32'hDEADBEEF;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            hist_v[i]  = 1'b0;
            hist[i]    = '0;
            in_data[i] = 32'hDEADBEEF;
        end
        sb_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_count"},     count,     0);
        check({tag, "_overflow"},  overflow,  0);
        check({tag, "_in_ready"},  in_ready,  1);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        clear_inputs();
        #1;
        check_reset_state(tag);
        step();
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor: every pop must match the oldest expected vector.
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("pop_with_empty_scoreboard", 32'(sb_q.size()), 1);
            end else begin
                sb_exp = sb_q.pop_front();
                check("pop_data", out_data, sb_exp);
            end
        end
    end

    initial begin
        vec_t s2v [4];
        vec_t v;
        s2v[0] = mkv(32'h41A00000);
        s2v[1] = mkv(32'h40800000);
        s2v[2] = mkv(32'h00000000);
        s2v[3] = mkv(32'h41200000);

        clear_inputs();
        step();
        do_reset("rst0");

        // Single vector: out_valid only at cycle 4.
        for (int c = 0; c < 10; c++) begin
            drive(c == 0, mkv(32'h41A00000), 1'b1);
            if (c == 0) sb_q.push_back(mkv(32'h41A00000));
            @(negedge clock);
            check($sformatf("s1_valid_c%0d", c), out_valid, (c == 4));
            step();
        end

        // Streaming four back-to-back vectors with out_ready held high.
        for (int c = 0; c < 12; c++) begin
            v = (c < 4) ? s2v[c] : '0;
            drive(c < 4, v, 1'b1);
            if (c < 4) sb_q.push_back(v);
            @(negedge clock);
            check($sformatf("s2_valid_c%0d", c), out_valid, (c >= 4 && c <= 7));
            check($sformatf("s2_count_c%0d", c), count, (c >= 4 && c <= 7) ? 1 : 0);
            step();
        end

        // Credit with out_ready low, two launches.
        for (int c = 0; c < 8; c++) begin
            v = mkl(32'h3F800000 + 32'(c * 16));
            drive(c < 2, v, 1'b0);
            if (c < 2) sb_q.push_back(v);
            @(negedge clock);
            check($sformatf("s3_in_ready_c%0d", c), in_ready, (c <= 1));
            check($sformatf("s3_count_c%0d", c), count, (c < 4) ? 0 : (c == 4) ? 1 : 2);
            check($sformatf("s3_overflow_c%0d", c), overflow, 0);
            step();
        end
        for (int c = 8; c < 12; c++) begin
            drive(1'b0, '0, 1'b1);
            @(negedge clock);
            step();
        end
        check("s3_in_ready_drained", in_ready, 1);
        check("s3_count_drained", count, 0);

        // Overflow: third launch ignores credit and is dropped.
        for (int c = 0; c < 10; c++) begin
            v = mkl(32'h40400000 + 32'(c * 16));
            drive(c < 3, v, 1'b0);
            if (c < 2) sb_q.push_back(v);
            @(negedge clock);
            check($sformatf("s4_overflow_c%0d", c), overflow, (c >= 6));
            if (c == 9) begin
                check("s4_count_full", count, 2);
                check("s4_head_vec0", out_data, mkl(32'h40400000));
            end
            step();
        end
        for (int c = 10; c < 13; c++) begin
            drive(1'b0, '0, 1'b1);
            @(negedge clock);
            step();
        end
        check("s4_overflow_held", overflow, 1);
        check("s4_count_drained", count, 0);

        // Reset mid-flight: one vector buffered, two in the deskew line.
        for (int c = 0; c < 6; c++) begin
            v = mkl(32'h50000000 + 32'(c * 16));
            drive(c == 0 || c == 3 || c == 4, v, 1'b0);
            if (c < 5) begin
                @(negedge clock);
                if (c == 4) check("s6_count_before_reset", count, 1);
                step();
            end
        end
        do_reset("s6_rst");
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, '0, 1'b1);
            @(negedge clock);
            check($sformatf("s6_no_valid_c%0d", c), out_valid, 0);
            step();
        end

        // Full FIFO with simultaneous push and pop.
        for (int c = 0; c < 12; c++) begin
            v = mkl(32'h60000000 + 32'(c * 16));
            drive(c < 3, v, (c == 5) || (c >= 7));
            if (c < 3) sb_q.push_back(v);
            @(negedge clock);
            if (c == 5) check("s5_count_full", count, 2);
            if (c == 6) begin
                check("s5_count_after_pushpop", count, 2);
                check("s5_overflow", overflow, 0);
                check("s5_head_vec1", out_data, mkl(32'h60000010));
            end
            step();
        end
        check("s5_count_drained", count, 0);
        check("s5_overflow_end", overflow, 0);
        check("scoreboard_empty", 32'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
